regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-cycle integer register file.
- Provides a configurable data width, a configurable depth, and N combinational read ports.
- Adds a per-register busy scoreboard, used for pipelined hazard detection.
- Adds a sequential clear engine that zeroes the whole file on request, without a global reset.
- Sits between the decode stage (read and issue) and the writeback stage (write) of the pipelined RV32I core.

Parameters:
- DATA_W, 32, width of each register.
- ADDR_W, 5, register address width. DEPTH = 2**ADDR_W is a derived localparam, not overridable.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rs_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- rs_data_o  out  NUM_RD*DATA_W  read data, port k in slice [k*DATA_W +: DATA_W].
- rs_busy_o  out  NUM_RD  port k's source register has an outstanding producer.
- rd_addr_i  in  ADDR_W  writeback address.
- rd_data_i  in  DATA_W  writeback data.
- rd_wren_i  in  1  writeback enable.
- iss_valid_i  in  1  an instruction writing iss_addr_i has been issued.
- iss_addr_i  in  ADDR_W  destination of the issued instruction.
- clr_req_i  in  1  start a clear sweep (level sampled in IDLE).
- clr_busy_o  out  1  sweep in progress.
- clr_done_o  out  1  one-cycle pulse at the end of a sweep.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - all registers are 0 and all busy bits are 0;
  - the FSM is in IDLE with sweep pointer 1;
  - clr_busy_o=0 and clr_done_o=0;
  - rs_data_o and rs_busy_o follow from the reset state (all 0).
  - Reset asserted mid-sweep aborts the sweep immediately; no done pulse is produced.
- Register 0:
  - reads 0 and is never busy;
  - writes and issues to address 0 are ignored.
- Reads:
  - combinational, zero latency;
  - rs_data_o[k] = reg[rs_addr_k];
  - rs_busy_o[k] = busy[rs_addr_k].
- Write:
  - at posedge, if rd_wren_i && rd_addr_i!=0 && state!=CLEAR, then reg[rd_addr_i] <= rd_data_i and busy[rd_addr_i] <= 0.
- Issue:
  - at posedge, if iss_valid_i && iss_addr_i!=0 && state!=CLEAR, then busy[iss_addr_i] <= 1.
  - If the issue and the write target the same address in the same cycle, set wins: busy ends at 1 and the data is still written.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clr_req_i=1; the pointer is loaded with 1.
  - In CLEAR, each cycle: reg[ptr] <= 0, busy[ptr] <= 0, ptr++.
  - CLEAR -> DONE in the cycle that ptr==DEPTH-1 is cleared.
  - DONE -> IDLE after one cycle.
  - clr_busy_o=1 in CLEAR.
  - clr_done_o=1 in DONE only.
  - A sweep lasts exactly DEPTH-1 cycles in CLEAR plus 1 cycle in DONE. With defaults that is 31+1.
  - clr_req_i is ignored in CLEAR and DONE; it is re-sampled in IDLE, so a held request restarts the sweep.
  - rd_wren_i and iss_valid_i are dropped, not queued, while in CLEAR.
  - Reads during CLEAR return current contents: already-cleared entries read 0, the rest hold old values.
- The pointer is ADDR_W bits wide and does not wrap inside a sweep.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined, write-through forwarding applies on port k when rd_wren_i && rd_addr_i==rs_addr_k && rd_addr_i!=0 && state!=CLEAR:
  - rs_data_o[k] = rd_data_i in the same cycle;
  - rs_busy_o[k] = (iss_valid_i && iss_addr_i==rd_addr_i).
- When undefined, reads return the pre-write register value and pre-write busy bit; the written value is visible the cycle after.

Decomposition:
- Package regfile_pkg holds:
  - the defaults DATA_W=32 and ADDR_W=5;
  - typedef clr_state_e {IDLE, CLEAR, DONE} as a 2-bit enum;
  - the constant ZERO_REG = '0.
- Sub-module regfile_clr_fsm contains the state register, the pointer, clr_busy_o and clr_done_o.
  - It exports a per-cycle clear strobe and the pointer to the storage array.
- Storage, scoreboard and read muxing stay in the top module, using generate loops over NUM_RD.

Test Plan:
1. Reset, then write x5=0xDEADBEEF. Next cycle, reading x5 returns 0xDEADBEEF and x0 returns 0. Write x0=0x1234, then read x0 -> 0.
2. Issue x7, then write x7 with 0xA5A5A5A5 two cycles later:
   - rs_busy_o for x7 is 1 for 2 cycles, then 0;
   - issue and write to x7 in the same cycle -> busy remains 1.
3. Fill x1..x31 with their indices, then pulse clr_req_i:
   - clr_busy_o is high for 31 cycles and clr_done_o pulses once;
   - all reads return 0 and all busy bits are 0;
   - a write to x3 mid-sweep is dropped (x3 reads 0 after the sweep).
4. Assert rst_i at the 10th cycle of a sweep -> outputs are 0 immediately, the FSM returns to IDLE, and no clr_done_o pulse occurs.
5. With REGFILE_BYPASS_EN, write x9=0x55 while port 1 reads x9 -> rs_data_o port 1 = 0x55 in the same cycle. Without the macro -> old value, then 0x55 the next cycle.
6. With NUM_RD=4 and DATA_W=64, all four ports read distinct registers holding 64-bit patterns, and the slices map correctly.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, constants and the clear-engine state type for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned ZERO_REG   = '0;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks a pointer over entries 1..DEPTH-1, one per cycle,
// then pulses done for a single cycle before returning to idle.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_req_i,
    output logic              clr_stb_o,
    output logic [ADDR_W-1:0] clr_ptr_o,
    output logic              clr_busy_o,
    output logic              clr_done_o
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FirstPtr = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_stb_o  = 1'b0;
        clr_busy_o = 1'b0;
        clr_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    ptr_d   = FirstPtr;
                end
            end
            CLEAR: begin
                clr_stb_o  = 1'b1;
                clr_busy_o = 1'b1;
                // Park the pointer at 1 on the last entry so it never wraps to 0.
                if (ptr_q == LastPtr) begin
                    state_d = DONE;
                    ptr_d   = FirstPtr;
                end else begin
                    ptr_d = ptr_q + FirstPtr;
                end
            end
            DONE: begin
                clr_done_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= FirstPtr;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign clr_ptr_o = ptr_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard and sequential clear engine.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rs_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rs_data_o,
    output logic [NUM_RD-1:0]        rs_busy_o,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        rd_data_i,
    input  logic                     rd_wren_i,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

    logic              clr_stb;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_en;
    logic              iss_en;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_req_i  (clr_req_i),
        .clr_stb_o  (clr_stb),
        .clr_ptr_o  (clr_ptr),
        .clr_busy_o (clr_busy_o),
        .clr_done_o (clr_done_o)
    );

    assign wr_en  = rd_wren_i && (rd_addr_i != ZeroAddr) && !clr_stb;
    assign iss_en = iss_valid_i && (iss_addr_i != ZeroAddr) && !clr_stb;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (clr_stb) begin
            regs_d[clr_ptr] = '0;
            busy_d[clr_ptr] = 1'b0;
        end else begin
            if (wr_en) begin
                regs_d[rd_addr_i] = rd_data_i;
                busy_d[rd_addr_i] = 1'b0;
            end
            // Issue after write so a same-cycle issue to the written register keeps it busy.
            if (iss_en) begin
                busy_d[iss_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rs_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = wr_en && (rd_addr_i == addr);
        assign rs_data_o[k*DATA_W +: DATA_W] = fwd ? rd_data_i : regs_q[addr];
        assign rs_busy_o[k] = fwd ? (iss_valid_i && (iss_addr_i == rd_addr_i)) : busy_q[addr];
`else
        assign rs_data_o[k*DATA_W +: DATA_W] = regs_q[addr];
        assign rs_busy_o[k] = busy_q[addr];
`endif
    end

endmodule
